// File: rtl/tx_frame_scheduler.sv
// Frame scheduler for the RS-485 telemetry transmitter: fetches WORDS words per period from the
// service/telemetry sources, strobes them into the transmitter, then re-arms it with one extra write.
module tx_frame_scheduler #(
  parameter int          WORDS        = 97,
  parameter int          SVC_SLOTS    = 4,
  parameter int          FRAME_PERIOD = 50000,
  parameter int          RD_TIMEOUT   = 16,
  parameter int          TX_TIMEOUT   = 40000,
  parameter logic [17:0] FILL_WORD    = 18'h0
) (
  input  logic        clk5MHz,
  input  logic        rst_n,
  output logic        svc_rd,
  output logic [6:0]  svc_addr,
  input  logic        svc_vld,
  input  logic [17:0] svc_data,
  output logic        tlm_rd,
  output logic [6:0]  tlm_addr,
  input  logic        tlm_vld,
  input  logic [17:0] tlm_data,
  output logic        wrEn,
  output logic [17:0] data_in,
  input  logic        accept,
  input  logic        clr,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        underrun,
  output logic        overrun,
  output logic        tx_err
);

  localparam int PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int CW = $clog2((TX_TIMEOUT > RD_TIMEOUT) ? TX_TIMEOUT : RD_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_STB_H, S_STB_L, S_WAIT_ACC, S_WAIT_DONE, S_ARM
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     slot_q, slot_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  timer_q, timer_d;
  logic           pending_q, pending_d;
  logic           busy_q, busy_d;
  logic [17:0]    data_q, data_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           underrun_q, underrun_d;
  logic           overrun_q, overrun_d;
  logic           tx_err_q, tx_err_d;
  logic           tx_fail_q, tx_fail_d;

  logic wrap, use_svc, tx_exp, set_under, set_tx, pend_take;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    tx_fail_d   = tx_fail_q;
    set_under   = 1'b0;
    set_tx      = 1'b0;
    pend_take   = 1'b0;

    wrap    = (timer_q == PW'(FRAME_PERIOD - 1));
    timer_d = wrap ? '0 : timer_q + PW'(1);
    use_svc = (slot_q < 7'(SVC_SLOTS));
    tx_exp  = (cnt_q == CW'(TX_TIMEOUT - 1));

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          pend_take = 1'b1;
          slot_d    = '0;
          busy_d    = 1'b1;
          tx_fail_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // only the source that was asked may answer; the other one's vld is ignored
        if (use_svc ? svc_vld : tlm_vld) begin
          data_d  = use_svc ? svc_data : tlm_data;
          cnt_d   = '0;
          state_d = S_STB_H;
        end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
          data_d    = FILL_WORD;
          set_under = 1'b1;
          cnt_d     = '0;
          state_d   = S_STB_H;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STB_H: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_STB_L;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STB_L: begin
        if (cnt_q == CW'(1)) begin
          cnt_d = '0;
          if (slot_q == 7'(WORDS - 1)) begin
            state_d = S_WAIT_ACC;
          end else begin
            slot_d  = slot_q + 7'd1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_ACC, S_WAIT_DONE: begin
        // one timeout window covers both the rise and the fall of accept
        if (tx_exp) begin
          set_tx    = 1'b1;
          tx_fail_d = 1'b1;
          data_d    = FILL_WORD;
          cnt_d     = '0;
          state_d   = S_ARM;
        end else if (state_q == S_WAIT_ACC && accept) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_WAIT_DONE;
        end else if (state_q == S_WAIT_DONE && !accept) begin
          data_d  = FILL_WORD;
          cnt_d   = '0;
          state_d = S_ARM;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ARM: begin
        if (cnt_q == CW'(3)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (!tx_fail_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    pending_d  = wrap ? 1'b1 : (pend_take ? 1'b0 : pending_q);
    overrun_d  = (wrap && busy_q) ? 1'b1 : (clr ? 1'b0 : overrun_q);
    underrun_d = set_under ? 1'b1 : (clr ? 1'b0 : underrun_q);
    tx_err_d   = set_tx ? 1'b1 : (clr ? 1'b0 : tx_err_q);
  end

  always_ff @(posedge clk5MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tx_err_q    <= 1'b0;
      tx_fail_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      tx_err_q    <= tx_err_d;
      tx_fail_q   <= tx_fail_d;
    end
  end

  // addresses are gated so they read 0 whenever no request is out
  assign svc_rd    = (state_q == S_FETCH) && use_svc;
  assign tlm_rd    = (state_q == S_FETCH) && !use_svc;
  assign svc_addr  = svc_rd ? slot_q : 7'd0;
  assign tlm_addr  = tlm_rd ? (slot_q - 7'(SVC_SLOTS)) : 7'd0;
  assign wrEn      = (state_q == S_STB_H) || ((state_q == S_ARM) && (cnt_q < CW'(2)));
  assign data_in   = data_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  assign tx_err    = tx_err_q;

endmodule
